// File: rtl/dmem_pkg.sv
// Shared funct3 codes, FSM state type and byte-lane helpers for dmem_pipe.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return funct3 inside {F3_SB, F3_SH, F3_SW};
    end
    return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // {spill lanes in word W+1, lanes in word W}
  function automatic logic [7:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [7:0] base;
    case (funct3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational byte-lane alignment over a two-word little-endian window:
// load extraction with sign/zero extension, store data and byte-mask placement.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FUNCT3_W = 3
) (
  input  logic [FUNCT3_W-1:0] i_funct3,
  input  logic [1:0]          i_off,
  input  logic [2*XLEN-1:0]   i_win,
  input  logic [XLEN-1:0]     i_wdata,
  output logic [XLEN-1:0]     o_rdata,
  output logic [2*XLEN-1:0]   o_wwin,
  output logic [7:0]          o_wmask
);

  logic [XLEN-1:0] w_shr;
  logic [XLEN-1:0] w_wsz;
  logic            w_sext;

  always_comb begin
    w_shr   = XLEN'(i_win >> {i_off, 3'b000});
    w_sext  = ~i_funct3[2];
    o_rdata = '0;
    w_wsz   = '0;
    case (i_funct3[1:0])
      2'b00: begin
        o_rdata      = {{(XLEN-8){w_sext & w_shr[7]}}, w_shr[7:0]};
        w_wsz[7:0]   = i_wdata[7:0];
      end
      2'b01: begin
        o_rdata      = {{(XLEN-16){w_sext & w_shr[15]}}, w_shr[15:0]};
        w_wsz[15:0]  = i_wdata[15:0];
      end
      default: begin
        o_rdata      = w_shr;
        w_wsz        = i_wdata;
      end
    endcase
    o_wwin  = {{XLEN{1'b0}}, w_wsz} << {i_off, 3'b000};
    o_wmask = byte_mask(i_funct3, i_off);
  end

endmodule

// File: rtl/dmem_pipe.sv
// Handshaked RV32 data memory: one request per cycle, registered response one cycle after accept.
// Misaligned accesses fault, or split into two word accesses when DMEM_MISALIGN_SPLIT_EN is defined.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FUNCT3_W = 3,
  parameter int DEPTH    = 1024
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [FUNCT3_W-1:0] i_req_funct3,
  input  logic [XLEN-1:0]     i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  output logic                o_rsp_valid,
  output logic [XLEN-1:0]     o_rsp_rdata,
  output logic                o_rsp_fault
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0]     r_mem [DEPTH];
  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_fault;
  logic [XLEN-1:0]     r_rsp_rdata;
  logic [AW-1:0]       r_idx;
  logic [FUNCT3_W-1:0] r_funct3;
  logic [1:0]          r_off;
  logic                r_we;
  logic [XLEN-1:0]     r_wdata;

  logic [AW-1:0]       w_idx;
  logic [AW-1:0]       w_idx_nxt;
  logic [1:0]          w_off;
  logic                w_oor;
  logic                w_legal;
  logic                w_mis;
  logic                w_fault;
  logic                w_split;
  logic                w_accept;
  logic [XLEN-1:0]     w_req_rdata;
  logic [XLEN-1:0]     w_spl_rdata;
  logic [2*XLEN-1:0]   w_req_wwin;
  logic [2*XLEN-1:0]   w_spl_wwin;
  logic [7:0]          w_req_wmask;
  logic [7:0]          w_spl_wmask;
  logic                w_unused;

  assign w_idx     = i_req_addr[AW+1:2];
  assign w_off     = i_req_addr[1:0];
  assign w_idx_nxt = r_idx + AW'(1);
  assign w_oor     = |i_req_addr[XLEN-1:AW+2];
  assign w_legal   = is_legal(i_req_we, i_req_funct3);
  assign w_mis     = is_misaligned(i_req_funct3, w_off);
  assign w_accept  = i_req_valid && r_req_ready;

`ifdef DMEM_MISALIGN_SPLIT_EN
  // The upper half of a split needs word W+1 to exist.
  assign w_fault = !w_legal || w_oor || (w_mis && (w_idx == AW'(DEPTH-1)));
  assign w_split = w_mis && !w_fault;
`else
  assign w_fault = !w_legal || w_oor || w_mis;
  assign w_split = 1'b0;
`endif

  dmem_align #(.XLEN(XLEN), .FUNCT3_W(FUNCT3_W)) u_align_req (
    .i_funct3 (i_req_funct3),
    .i_off    (w_off),
    .i_win    ({{XLEN{1'b0}}, r_mem[w_idx]}),
    .i_wdata  (i_req_wdata),
    .o_rdata  (w_req_rdata),
    .o_wwin   (w_req_wwin),
    .o_wmask  (w_req_wmask)
  );

  dmem_align #(.XLEN(XLEN), .FUNCT3_W(FUNCT3_W)) u_align_spl (
    .i_funct3 (r_funct3),
    .i_off    (r_off),
    .i_win    ({r_mem[w_idx_nxt], r_mem[r_idx]}),
    .i_wdata  (r_wdata),
    .o_rdata  (w_spl_rdata),
    .o_wwin   (w_spl_wwin),
    .o_wmask  (w_spl_wmask)
  );

  assign w_unused = ^{w_req_wwin[2*XLEN-1:XLEN], w_req_wmask[7:4],
                      w_spl_wwin[XLEN-1:0], w_spl_wmask[3:0]};

  // Lower part commits at accept, upper part at the SPLIT edge.
  always_ff @(posedge clk) begin
    if (n_reset) begin
      if (w_accept && i_req_we && !w_fault) begin
        for (int b = 0; b < 4; b++) begin
          if (w_req_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_req_wwin[8*b +: 8];
        end
      end
      if (r_state == ST_SPLIT && r_we) begin
        for (int b = 0; b < 4; b++) begin
          if (w_spl_wmask[4+b]) r_mem[w_idx_nxt][8*b +: 8] <= w_spl_wwin[XLEN+8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
      r_idx       <= '0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_split) begin
              r_state     <= ST_SPLIT;
              r_req_ready <= 1'b0;
              r_idx       <= w_idx;
              r_funct3    <= i_req_funct3;
              r_off       <= w_off;
              r_we        <= i_req_we;
              r_wdata     <= i_req_wdata;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= w_fault;
              r_rsp_rdata <= (w_fault || i_req_we) ? '0 : w_req_rdata;
            end
          end
        end
        ST_SPLIT: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_fault <= 1'b0;
          r_rsp_rdata <= r_we ? '0 : w_spl_rdata;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe: byte-array reference model, directed cases then random traffic.
module tb_dmem_pipe;
  import dmem_pkg::*;

  localparam int XLEN     = 32;
  localparam int FUNCT3_W = 3;
  localparam int DEPTH    = 1024;
  localparam int NBYTES   = 4 * DEPTH;

  logic                clk = 1'b0;
  logic                n_reset = 1'b0;
  logic                i_req_valid = 1'b0;
  logic                i_req_we = 1'b0;
  logic [FUNCT3_W-1:0] i_req_funct3 = '0;
  logic [XLEN-1:0]     i_req_addr = '0;
  logic [XLEN-1:0]     i_req_wdata = '0;
  logic                o_req_ready;
  logic                o_rsp_valid;
  logic [XLEN-1:0]     o_rsp_rdata;
  logic                o_rsp_fault;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [NBYTES];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;

  dmem_pipe #(.XLEN(XLEN), .FUNCT3_W(FUNCT3_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_fault  (o_rsp_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: memory as a flat byte array, access size and legality from funct3.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output bit fault, output bit split);
    int  size;
    bit  legal;
    bit  mis;
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    fault = !legal || (longint'(addr) >= longint'(NBYTES));
    mis   = legal && (addr % size != 0);
    split = 1'b0;
    rd    = '0;
    if (!fault && mis) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
      if (addr / 4 + 1 >= DEPTH) fault = 1'b1;
      else split = 1'b1;
`else
      fault = 1'b1;
`endif
    end
    if (!fault) begin
      if (we) begin
        for (int i = 0; i < size; i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = mem_m[int'(addr) + i];
        if (size < 4 && !f3[2] && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (o_rsp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata %h fault %b with nothing expected (cycle %0d)",
                 o_rsp_rdata, o_rsp_fault, cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_cycle", cyc, e.cyc);
        check("rsp_rdata", o_rsp_rdata, e.rdata);
        check("rsp_fault", 32'(o_rsp_fault), 32'(e.fault));
      end
    end
  end

  task automatic issue2(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit has_lit, input logic [31:0] lit);
    logic [31:0] rd;
    bit          fault;
    bit          split;
    exp_t        e;
    int          guard;
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wd;
    guard = 0;
    while (o_req_ready !== 1'b1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", 32'(o_req_ready), 32'd1);
    if (o_req_ready !== 1'b1) begin
      i_req_valid = 1'b0;
      return;
    end
    model(we, f3, addr, wd, rd, fault, split);
    e.rdata = has_lit ? lit : rd;
    e.fault = fault;
    e.cyc   = cyc + (split ? 2 : 1);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    issue2(we, f3, addr, wd, 1'b0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(o_req_ready), 32'd1);
    check({tag, "_valid"}, 32'(o_rsp_valid), 32'd0);
    check({tag, "_rdata"}, o_rsp_rdata, 32'd0);
    check({tag, "_fault"}, 32'(o_rsp_fault), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_reset = 1'b1;

    for (int w = 0; w < 66; w++) issue(1'b1, F3_SW, 32'(4 * w), $urandom);
    issue(1'b1, F3_SW, 32'(4 * (DEPTH - 2)), $urandom);
    issue(1'b1, F3_SW, 32'(4 * (DEPTH - 1)), $urandom);

    issue(1'b1, F3_SW, 32'h10, 32'h80FF7F01);
    issue2(1'b0, F3_LB,  32'h10, 32'h0, 1'b1, 32'h0000_0001);
    issue2(1'b0, F3_LB,  32'h13, 32'h0, 1'b1, 32'hFFFF_FF80);
    issue2(1'b0, F3_LBU, 32'h13, 32'h0, 1'b1, 32'h0000_0080);
    issue2(1'b0, F3_LH,  32'h12, 32'h0, 1'b1, 32'hFFFF_80FF);
    issue2(1'b0, F3_LHU, 32'h12, 32'h0, 1'b1, 32'h0000_80FF);

    issue(1'b1, F3_SW, 32'h20, 32'hAABBCCDD);
    issue(1'b1, F3_SB, 32'h21, 32'h0000_0011);
    issue(1'b1, F3_SH, 32'h22, 32'h0000_2233);
    issue2(1'b0, F3_LW, 32'h20, 32'h0, 1'b1, 32'h223311DD);
    @(negedge clk);
    check("rsp_hold_valid", 32'(o_rsp_valid), 32'd0);
    check("rsp_hold_rdata", o_rsp_rdata, 32'h223311DD);

    issue(1'b1, F3_SW, 32'h30, 32'h5A5AC3C3);
    issue2(1'b0, F3_LW, 32'h30, 32'h0, 1'b1, 32'h5A5AC3C3);

    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b1, 3'b011, 32'h10, 32'hDEADBEEF);
    issue(1'b1, F3_SW, 32'h0000_1010, 32'hDEADBEEF);
    issue(1'b1, F3_SB, 32'h8000_0013, 32'hDEADBEEF);
    issue(1'b0, F3_LW, 32'h0000_1010, 32'h0);
    issue2(1'b0, F3_LW, 32'h10, 32'h0, 1'b1, 32'h80FF7F01);
    issue(1'b0, F3_LW, 32'h01, 32'h0);
    issue(1'b1, F3_SW, 32'h02, 32'h13572468);
    issue(1'b0, F3_LW, 32'h00, 32'h0);
    issue(1'b0, F3_LW, 32'h04, 32'h0);

`ifdef DMEM_MISALIGN_SPLIT_EN
    issue(1'b1, F3_SW, 32'h0, 32'h44332211);
    issue(1'b1, F3_SW, 32'h4, 32'h88776655);
    issue2(1'b0, F3_LW, 32'h3, 32'h0, 1'b1, 32'h77665544);
    check("split_ready_low", 32'(o_req_ready), 32'd0);
    @(negedge clk);
    check("split_ready_back", 32'(o_req_ready), 32'd1);
    issue(1'b1, F3_SH, 32'h3, 32'h0000BEEF);
    issue2(1'b0, F3_LW, 32'h0, 32'h0, 1'b1, 32'hEF332211);
    issue2(1'b0, F3_LW, 32'h4, 32'h0, 1'b1, 32'h887766BE);
    issue(1'b0, F3_LW, 32'(NBYTES - 2), 32'h0);

    // Split store abandoned by reset: only the lower-word bytes land.
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = F3_SW;
    i_req_addr   = 32'h6;
    i_req_wdata  = 32'hA1B2C3D4;
    check("pre_split_ready", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    check("split_store_ready_low", 32'(o_req_ready), 32'd0);
    n_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid_split");
    n_reset = 1'b1;
    mem_m[6] = 8'hD4;
    mem_m[7] = 8'hC3;
    issue(1'b0, F3_LW, 32'h4, 32'h0);
    issue(1'b0, F3_LW, 32'h8, 32'h0);
`else
    issue(1'b0, F3_LW, 32'h8, 32'h0);
    n_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_after_rsp");
    n_reset = 1'b1;
    issue(1'b0, F3_LW, 32'h8, 32'h0);
`endif

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [2:0]  f;
      bit          we;
      int          r;
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom | 32'h0000_1000;
      else if (r == 1) a = 32'(4 * (DEPTH - 2)) + 32'($urandom_range(0, 7));
      else a = 32'($urandom_range(0, 255));
      f  = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      issue(we, f, a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Parametrised, handshaked data memory for the RV32IM core, replacing the single-cycle combinational-read data memory in the MEM stage. It accepts one load/store request per cycle through a valid/ready handshake. It returns a registered response one cycle later, with byte/halfword/word sizing, sign/zero extension, per-byte write enables, and fault reporting for out-of-range or illegal accesses. Misaligned accesses either fault or are split into two word accesses, selected at compile time.

## Interface
- XLEN, 32: data and address width.
- FUNCT3_W, 3: width of the access-size code.
- DEPTH, 1024: memory depth in XLEN-bit words; power of two, at least 2.
- clk  in  1  clock.
- n_reset  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  FUNCT3_W  RISC-V load/store funct3.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access faulted; qualified by rsp_valid.

## Operation
- **Handshake.** A request is accepted on a rising edge where req_valid and req_ready are both 1. Requests with req_ready=0 are ignored; the requester holds them.
- **Addressing.** Memory is little-endian: byte k of a word occupies bits 8k+7:8k. Word index = req_addr[log2(DEPTH)+1:2].
- **Legal loads.** funct3 LB=000, LH=001, LW=010, LBU=100, LHU=101.
- **Legal stores.** funct3 SB=000, SH=001, SW=010.
- **Illegal funct3.** Any other code faults: rsp_fault=1, no memory change.
- **Out of range.** Address bits above the index (req_addr[XLEN-1:log2(DEPTH)+2]) nonzero → fault, no write.
- **Stores.** Only the addressed byte lanes are written; the other lanes keep their values.
- **Misaligned.** Halfword with addr[0]=1; word with addr[1:0]≠0.
- **State machine.**
  - IDLE: req_ready=1. An aligned or faulting request stays in IDLE. A misaligned request, with split enabled, goes to SPLIT.
  - SPLIT: req_ready=0. Accesses word index+1, then returns to IDLE.
- **Store semantics.** Stores are committed at the accept edge (and the SPLIT edge for the upper part).

## Timing
- **Aligned or faulting access.** Accepted at edge E0; rsp_valid=1 for exactly the cycle after E0.
- **Split access.** Accepted at E0, SPLIT at E1; rsp_valid=1 for the cycle after E1. Throughput is one access per 2 cycles.
- **Back-to-back.** Aligned requests can be accepted every cycle.
- **Read-after-write.** A load accepted at the edge after a store's accept edge returns the new data. No same-edge bypass is needed, since accepts are serial.
- **Reset values.** State=IDLE, req_ready=1 from the first cycle after reset, rsp_valid=0, rsp_rdata=0, rsp_fault=0. Memory contents are not reset.
- **Reset mid-split.** The SPLIT state is abandoned and no response is issued. The lower-word part of a split store, already committed, stays.
- **Response outputs.** rsp_rdata and rsp_fault are held from the last response while rsp_valid=0.

## Configuration
- **DMEM_MISALIGN_SPLIT_EN defined.** Misaligned in-range accesses use SPLIT. Lower bytes come from/go to word W, upper bytes from/to word W+1. If W+1 ≥ DEPTH, the access faults at accept with no write.
- **DMEM_MISALIGN_SPLIT_EN undefined.** Misaligned accesses fault with 1-cycle latency and no memory change. SPLIT is unreachable and may be removed.

## Structure
- **Package dmem_pkg.** Holds the funct3 constants for loads and stores, the state enum (IDLE, SPLIT), and the byte-enable mask function (funct3, addr[1:0]) → 4-bit lane mask plus spill mask.
- **Sub-module dmem_align.** Purely combinational, two instances. It handles load byte-lane extraction with sign/zero extension over a concatenated two-word window, and store data/lane-mask alignment. The top level holds the array, the FSM and the response registers.

## Test plan
- **Byte store/load.** SW 0x80FF7F01 to 0x10, then LB 0x10, LB 0x13, LBU 0x13, LH 0x12, LHU 0x12 → 0x00000001, 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF, each with fault=0 and one cycle of latency.
- **Lane isolation.** SW 0xAABBCCDD to 0x20, SB 0x11 to 0x21, SH 0x2233 to 0x22, LW 0x20 → 0x223311DD.
- **Back-to-back.** Store accepted, load of the same address accepted the next cycle → load response equals the stored value; rsp_valid high on two consecutive cycles.
- **Faults.** Each of the following gives rsp_fault=1, rdata=0 and memory unchanged on a later LW:
  - funct3=011 load;
  - an address with bits above log2(DEPTH)+2 set;
  - LW at 0x01 with the macro undefined.
- **Split (macro defined).** Memory word 0 = 0x44332211, word 1 = 0x88776655.
  - LW at 0x03 → 0x77665544 two cycles after accept; req_ready low for one cycle.
  - SH 0xBEEF at 0x03 → words become 0xEF332211 and 0x887766BE.
  - LW at byte address 4·DEPTH−2 faults.
- **Reset in SPLIT.** Assert n_reset during SPLIT → no response; req_ready=1, rsp_valid=0 the cycle after reset; the next aligned load completes normally.
